// File: rtl/ram.sv
// ram: word-organised instruction/data memory, Avalon-MM slave to the CPU,
// with a second preload port for the harness to write whole instruction words.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   RAM_Reset    synchronous active-high reset, clears memory and slave state
//   address      Avalon byte address (word index = address[ADDR_W+1:2])
//   write/read   Avalon strobes
//   waitrequest  Avalon stall
//   writedata    Avalon write data
//   byteenable   write byte lanes
//   readdata     Avalon read data (0 when not reading)
//   instruction  preload data word
//   inst_input   preload enable
//   inst_addr    preload byte address
//
// Optional build macro RAM_WAIT_EN: inserts WAIT_CYCLES wait states per
// transfer. Without it, waitrequest is tied low.

module ram #(
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        RAM_Reset,
    input  logic [31:0] address,
    input  logic        write,
    input  logic        read,
    output logic        waitrequest,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    input  logic [31:0] instruction,
    input  logic        inst_input,
    input  logic [7:0]  inst_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] bus_idx;
    logic [ADDR_W-1:0] pre_idx;
    logic [31:0]       inst_ext;
    logic              bus_wr;
    logic              unused_bits;

    // Zero-extend so narrow preload addresses still reach every word.
    assign inst_ext = {24'b0, inst_addr};
    assign bus_idx  = address[ADDR_W+1:2];
    assign pre_idx  = inst_ext[ADDR_W+1:2];

    // Byte offset and high address bits alias onto the same words.
    assign unused_bits = ^{address[31:ADDR_W+2], address[1:0],
                           inst_ext[31:ADDR_W+2], inst_ext[1:0],
                           WAIT_CYCLES != 0};

`ifdef RAM_WAIT_EN
    localparam logic [3:0] WAIT_TGT = 4'(WAIT_CYCLES);

    logic [3:0] wait_cnt;
    logic       req;

    assign req = read | write;

    // Stall until the counter reaches the target; the cycle with the
    // counter at target is the single completion cycle.
    assign waitrequest = req && !RAM_Reset && (wait_cnt != WAIT_TGT);

    always_ff @(posedge clk) begin
        if (RAM_Reset) begin
            wait_cnt <= '0;
        end else if (!req || !waitrequest) begin
            // Idle, aborted, or just completed: next request starts fresh.
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end
`else
    assign waitrequest = 1'b0;
`endif

    assign bus_wr = write && !waitrequest;

    always_ff @(posedge clk) begin
        if (RAM_Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (bus_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (byteenable[b]) begin
                        mem[bus_idx][8*b +: 8] <= writedata[8*b +: 8];
                    end
                end
            end
            // Placed last so a same-word preload overrides the bus write.
            if (inst_input) begin
                mem[pre_idx] <= instruction;
            end
        end
    end

    assign readdata = (read && !write && !waitrequest) ? mem[bus_idx] : '0;

endmodule

// File: tb/tb_ram.sv
// tb_ram: directed plus randomized checks of ram against a word-array model.
// Works for both the base build and the RAM_WAIT_EN build (WAIT_CYCLES=1).

module tb_ram;

    logic        clk = 1'b0;
    logic        RAM_Reset;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic [31:0] instruction;
    logic        inst_input;
    logic [7:0]  inst_addr;

    int checks = 0;
    int errors = 0;

    // Reference model: 64 words, indexed by byte address bits [7:2].
    logic [31:0] model [64];

`ifdef RAM_WAIT_EN
    localparam int EXP_WAIT = 1;
`else
    localparam int EXP_WAIT = 0;
`endif

    ram dut (
        .clk(clk),
        .RAM_Reset(RAM_Reset),
        .address(address),
        .write(write),
        .read(read),
        .waitrequest(waitrequest),
        .writedata(writedata),
        .byteenable(byteenable),
        .readdata(readdata),
        .instruction(instruction),
        .inst_input(inst_input),
        .inst_addr(inst_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[7:2]);
    endfunction

    // Hold the current request until waitrequest drops; returns stall count.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        #1;
        while (waitrequest !== 1'b0 && n < 20) begin
            check({tag, "_rd0_wait"}, readdata, 32'h0);
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_timeout"}, 32'(n < 20), 32'd1);
    endtask

    task automatic bus_read(input logic [31:0] a, input string tag);
        int n;
        @(negedge clk);
        address = a;
        read    = 1'b1;
        write   = 1'b0;
        wait_done(tag, n);
        check({tag, "_wait"}, 32'(n), 32'(EXP_WAIT));
        check(tag, readdata, model[widx(a)]);
        @(posedge clk);
        #1;
        read = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, input logic also_read,
                             input string tag);
        int n;
        @(negedge clk);
        address    = a;
        writedata  = d;
        byteenable = be;
        write      = 1'b1;
        read       = also_read;
        wait_done(tag, n);
        if (also_read) check({tag, "_rdw"}, readdata, 32'h0);
        @(posedge clk);
        #1;
        write = 1'b0;
        read  = 1'b0;
        for (int b = 0; b < 4; b++)
            if (be[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        inst_addr   = a;
        instruction = d;
        inst_input  = 1'b1;
        @(posedge clk);
        #1;
        inst_input = 1'b0;
        model[widx({24'b0, a})] = d;
    endtask

    // Bus write and preload held together so they land on the same edge.
    task automatic both(input logic [31:0] a, input logic [31:0] d,
                        input logic [7:0] pa, input logic [31:0] pd,
                        input string tag);
        int n;
        @(negedge clk);
        address     = a;
        writedata   = d;
        byteenable  = 4'hF;
        write       = 1'b1;
        inst_addr   = pa;
        instruction = pd;
        inst_input  = 1'b1;
        wait_done(tag, n);
        @(posedge clk);
        #1;
        write      = 1'b0;
        inst_input = 1'b0;
        model[widx(a)] = d;
        model[widx({24'b0, pa})] = pd;
    endtask

    task automatic do_reset(input logic with_preload);
        @(negedge clk);
        RAM_Reset   = 1'b1;
        inst_input  = with_preload;
        inst_addr   = 8'h04;
        instruction = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        RAM_Reset  = 1'b0;
        inst_input = 1'b0;
        for (int i = 0; i < 64; i++) model[i] = '0;
    endtask

    initial begin
        RAM_Reset   = 1'b1;
        address     = '0;
        write       = 1'b0;
        read        = 1'b0;
        writedata   = '0;
        byteenable  = '0;
        instruction = '0;
        inst_input  = 1'b0;
        inst_addr   = '0;

        do_reset(1'b0);
        @(negedge clk);
        check("reset_wait", 32'(waitrequest), 32'd0);
        check("reset_rd_idle", readdata, 32'h0);
        bus_read(32'h0000_0000, "reset_w0");
        bus_read(32'h0000_00FC, "reset_w63");

        preload(8'h04, 32'h24020069);
        preload(8'h08, 32'h00000008);
        bus_read(32'h04, "pre_04");
        bus_read(32'h08, "pre_08");
        bus_read(32'h0C, "pre_0c");
        check("pre_04_lit", model[1], 32'h24020069);

        bus_write(32'h04, 32'hAABBCCDD, 4'b0011, 1'b0, "be_0011");
        bus_read(32'h04, "be_0011_rd");
        check("be_0011_lit", model[1], 32'h2402CCDD);
        bus_write(32'h04, 32'h11223344, 4'b0000, 1'b0, "be_0000");
        bus_read(32'h04, "be_0000_rd");

        preload(8'h10, 32'h12345678);
        bus_read(32'h0000_0110, "alias_110");
        bus_read(32'h0000_0013, "alias_013");

        bus_write(32'h30, 32'hCAFEF00D, 4'hF, 1'b1, "rw_both");
        bus_read(32'h30, "rw_both_rd");

        both(32'h20, 32'hFFFFFFFF, 8'h20, 32'h0000ABCD, "same_word");
        bus_read(32'h20, "same_word_rd");
        @(negedge clk);
        address = 32'h20;
        read    = 1'b0;
        #1;
        check("read_low", readdata, 32'h0);

        both(32'h28, 32'h5A5A5A5A, 8'h24, 32'hA5A5A5A5, "diff_word");
        bus_read(32'h24, "diff_word_pre");
        bus_read(32'h28, "diff_word_bus");

        for (int k = 0; k < 80; k++) begin
            logic [31:0] ra;
            logic [31:0] rd;
            ra = $urandom;
            rd = $urandom;
            case ($urandom_range(0, 2))
                0: bus_write(ra, rd, 4'($urandom_range(0, 15)), 1'b0, "rnd_wr");
                1: preload(ra[7:0], rd);
                default: bus_read(ra, "rnd_rd");
            endcase
        end

        do_reset(1'b1);
        for (int i = 0; i < 64; i++) bus_read(32'(i * 4), "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
